// File: rtl/mem_wb_stage.sv
// MEM stage with data-memory handshake and MEM/WB pipeline register.
// Drives the forwarding taps and the upstream stall while an access is outstanding.
module mem_wb_stage #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_mem,
    input  logic [31:0] store_data_mem,
    input  logic [4:0]  rd_addr_mem,
    input  logic        wb_en_mem,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3_mem,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall_mem,
    output logic [31:0] fw_from_mem,
    output logic [4:0]  rd_addr_wb,
    output logic        wb_en_wb,
    output logic [31:0] wb_data,
    output logic [31:0] fw_from_wb,
    output logic        mis_err,
    output logic        bus_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_q;
    logic [3:0]         we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [4:0]         rd_q;
    logic               wen_q;
    logic [31:0]        wbd_q;
    logic               mis_q;
    logic               bus_q;

    logic               mem_op;
    logic               aligned;
    logic               access;
    logic               misal;
    logic               timeout;

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~a[0];
            default: return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = 8'(rdata >> {a, 3'b000});
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    assign mem_op  = mem_rd | mem_wr;
    assign aligned = is_aligned(funct3_mem, alu_out_mem[1:0]);
    assign access  = mem_op & aligned;
    assign misal   = mem_op & ~aligned;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // An ack arriving on the timeout cycle still completes normally.
    assign stall_mem = access & ~((state_q == BUSY) & (dm_ack | timeout));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 4'b0000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
            wen_q   <= 1'b0;
            wbd_q   <= 32'd0;
            mis_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            mis_q <= 1'b0;
            bus_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        addr_q  <= {alu_out_mem[31:2], 2'b00};
                        we_q    <= mem_wr ? store_strobe(funct3_mem, alu_out_mem[1:0]) : 4'b0000;
                        wdata_q <= mem_wr ? store_lanes(funct3_mem, store_data_mem) : 32'd0;
                        rd_q    <= 5'd0;
                        wen_q   <= 1'b0;
                    end else begin
                        rd_q  <= rd_addr_mem;
                        wen_q <= wb_en_mem & ~misal;
                        wbd_q <= alu_out_mem;
                        mis_q <= misal;
                    end
                end
                BUSY: begin
                    if (dm_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 4'b0000;
                        rd_q    <= rd_addr_mem;
                        wen_q   <= wb_en_mem;
                        wbd_q   <= mem_rd ? load_align(funct3_mem, alu_out_mem[1:0], dm_rdata)
                                          : alu_out_mem;
                    end else if (timeout) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 4'b0000;
                        rd_q    <= 5'd0;
                        wen_q   <= 1'b0;
                        wbd_q   <= 32'd0;
                        bus_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        rd_q  <= 5'd0;
                        wen_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm_req      = req_q;
    assign dm_we       = we_q;
    assign dm_addr     = addr_q;
    assign dm_wdata    = wdata_q;
    assign fw_from_mem = alu_out_mem;
    assign rd_addr_wb  = rd_q;
    assign wb_en_wb    = wen_q;
    assign wb_data     = wbd_q;
    assign fw_from_wb  = wbd_q;
    assign mis_err     = mis_q;
    assign bus_err     = bus_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, loads/stores, misalignment, timeout, reset.
module tb_mem_wb_stage;
    localparam int TO = 64;

    logic        clk;
    logic        rst;
    logic [31:0] alu_out_mem;
    logic [31:0] store_data_mem;
    logic [4:0]  rd_addr_mem;
    logic        wb_en_mem;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3_mem;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        stall_mem;
    logic [31:0] fw_from_mem;
    logic [4:0]  rd_addr_wb;
    logic        wb_en_wb;
    logic [31:0] wb_data;
    logic [31:0] fw_from_wb;
    logic        mis_err;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wb_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .alu_out_mem(alu_out_mem), .store_data_mem(store_data_mem),
        .rd_addr_mem(rd_addr_mem), .wb_en_mem(wb_en_mem),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3_mem(funct3_mem),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall_mem(stall_mem),
        .fw_from_mem(fw_from_mem), .rd_addr_wb(rd_addr_wb), .wb_en_wb(wb_en_wb),
        .wb_data(wb_data), .fw_from_wb(fw_from_wb), .mis_err(mis_err), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input logic wen, input logic rdop, input logic wrop, input logic [2:0] f3);
        alu_out_mem    = a;
        store_data_mem = sd;
        rd_addr_mem    = rd;
        wb_en_mem      = wen;
        mem_rd         = rdop;
        mem_wr         = wrop;
        funct3_mem     = f3;
    endtask

    // Issue an aligned access, acknowledge it one cycle after dm_req rises.
    task automatic mem_access(input string tag, input logic [31:0] a, input logic [31:0] sd,
                              input logic rdop, input logic [2:0] f3, input logic [31:0] rdata,
                              input logic [3:0] exp_we, input logic [31:0] exp_wd,
                              input logic [31:0] exp_wb);
        drive(a, sd, 5'd12, rdop, rdop, ~rdop, f3);
        #1 chk({tag, "_stall"}, 32'(stall_mem), 32'd1);
        tick();
        chk({tag, "_req"}, 32'(dm_req), 32'd1);
        chk({tag, "_addr"}, dm_addr, {a[31:2], 2'b00});
        chk({tag, "_we"}, 32'(dm_we), 32'(exp_we));
        if (!rdop) chk({tag, "_wdata"}, dm_wdata, exp_wd);
        dm_ack = 1'b1;
        dm_rdata = rdata;
        tick();
        dm_ack = 1'b0;
        drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk({tag, "_wb"}, wb_data, exp_wb);
        chk({tag, "_reqoff"}, 32'(dm_req), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        dm_ack = 1'b0;
        dm_rdata = 32'd0;
        drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        #3;
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_we", 32'(dm_we), 32'd0);
        chk("rst_wb", wb_data, 32'd0);
        chk("rst_wen", 32'(wb_en_wb), 32'd0);
        chk("rst_err", 32'({mis_err, bus_err}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ALU pass-through
        drive(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b010);
        #1 chk("alu_stall", 32'(stall_mem), 32'd0);
        chk("alu_fwmem", fw_from_mem, 32'h1234);
        tick();
        chk("alu_wb", wb_data, 32'h1234);
        chk("alu_rd", 32'(rd_addr_wb), 32'd5);
        chk("alu_wen", 32'(wb_en_wb), 32'd1);
        chk("alu_fwwb", fw_from_wb, 32'h1234);

        // LB 0x103 with bubble checks during the stall cycle
        drive(32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
        #1 chk("lb_stall", 32'(stall_mem), 32'd1);
        tick();
        chk("lb_req", 32'(dm_req), 32'd1);
        chk("lb_addr", dm_addr, 32'h100);
        chk("lb_we", 32'(dm_we), 32'd0);
        chk("lb_bubble", 32'(wb_en_wb), 32'd0);
        chk("lb_hold", wb_data, 32'h1234);
        dm_ack = 1'b1;
        dm_rdata = 32'h80FF_FFFF;
        #1 chk("lb_stall_ack", 32'(stall_mem), 32'd0);
        tick();
        dm_ack = 1'b0;
        chk("lb_wb", wb_data, 32'hFFFF_FF80);
        chk("lb_rd", 32'(rd_addr_wb), 32'd7);
        chk("lb_wen", 32'(wb_en_wb), 32'd1);
        chk("lb_reqoff", 32'(dm_req), 32'd0);
        drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();

        // Stores and loads of every width / lane
        mem_access("sh", 32'h102, 32'h0000_ABCD, 1'b0, 3'b001, 32'd0, 4'b1100, 32'hABCD_ABCD, 32'h102);
        chk("sh_wen", 32'(wb_en_wb), 32'd0);
        mem_access("sb", 32'h001, 32'h5566_7712, 1'b0, 3'b000, 32'd0, 4'b0010, 32'h1212_1212, 32'h001);
        mem_access("sw", 32'h200, 32'hDEAD_BEEF, 1'b0, 3'b010, 32'd0, 4'b1111, 32'hDEAD_BEEF, 32'h200);
        mem_access("lhu", 32'h102, 32'd0, 1'b1, 3'b101, 32'h8001_0000, 4'b0000, 32'd0, 32'h0000_8001);
        mem_access("lh", 32'h102, 32'd0, 1'b1, 3'b001, 32'h8001_0000, 4'b0000, 32'd0, 32'hFFFF_8001);
        mem_access("lbu", 32'h101, 32'd0, 1'b1, 3'b100, 32'h0000_9A00, 4'b0000, 32'd0, 32'h0000_009A);
        mem_access("lw", 32'h204, 32'd0, 1'b1, 3'b010, 32'hCAFE_F00D, 4'b0000, 32'd0, 32'hCAFE_F00D);

        // Misaligned LW
        drive(32'h101, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
        #1 chk("mis_stall", 32'(stall_mem), 32'd0);
        tick();
        chk("mis_err", 32'(mis_err), 32'd1);
        chk("mis_req", 32'(dm_req), 32'd0);
        chk("mis_wen", 32'(wb_en_wb), 32'd0);
        drive(32'h55, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("mis_pulse", 32'(mis_err), 32'd0);
        chk("mis_next_wen", 32'(wb_en_wb), 32'd1);
        chk("mis_req2", 32'(dm_req), 32'd0);

        // Timeout on a withheld ack
        drive(32'h40, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010);
        tick();
        repeat (10) tick();
        chk("to_midreq", 32'(dm_req), 32'd1);
        chk("to_midstall", 32'(stall_mem), 32'd1);
        repeat (TO - 11) tick();
        chk("to_lastreq", 32'(dm_req), 32'd1);
        chk("to_laststall", 32'(stall_mem), 32'd0);
        tick();
        drive(32'h66, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000);
        chk("to_req", 32'(dm_req), 32'd0);
        chk("to_bus", 32'(bus_err), 32'd1);
        chk("to_wb", wb_data, 32'd0);
        chk("to_wen", 32'(wb_en_wb), 32'd0);
        tick();
        chk("to_buspulse", 32'(bus_err), 32'd0);
        chk("to_after", wb_data, 32'h66);

        // Ack on the timeout cycle completes normally
        drive(32'h80, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010);
        tick();
        repeat (TO - 1) tick();
        dm_ack = 1'b1;
        dm_rdata = 32'h1122_3344;
        tick();
        dm_ack = 1'b0;
        drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("race_wb", wb_data, 32'h1122_3344);
        chk("race_bus", 32'(bus_err), 32'd0);
        chk("race_wen", 32'(wb_en_wb), 32'd1);

        // Reset while BUSY, then a stray ack
        drive(32'h44, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010);
        tick();
        chk("rb_req", 32'(dm_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rb_reqoff", 32'(dm_req), 32'd0);
        chk("rb_addr", dm_addr, 32'd0);
        chk("rb_wb", wb_data, 32'd0);
        drive(32'h77, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        dm_ack = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        tick();
        dm_ack = 1'b0;
        chk("rb_ackign_req", 32'(dm_req), 32'd0);
        chk("rb_ackign_wb", wb_data, 32'h77);
        chk("rb_ackign_wen", 32'(wb_en_wb), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
